mmu_skew_feeder: RTL and testbench

Skewed read sequencer between the per-row input FIFOs and the left edge of the MMU systolic array. On `start_i` it drains exactly `VEC_LEN` words from each of `NUM_ROWS` show-ahead FIFOs, delaying row r by r cycles to form the diagonal wavefront the PE array needs. All rows advance in lockstep; if any row that must read in a cycle has an empty FIFO, the whole wavefront stalls. Outputs are registered and drive the PE row inputs directly.

---
 rtl/mmu_skew_feeder_if.sv | 27 ++
 rtl/mmu_skew_feeder.sv | 112 +++++++++++
 tb/tb_mmu_skew_feeder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mmu_skew_feeder_if.sv
// FIFO-side and PE-side signal bundle for the skewed MMU row feeder.
interface mmu_skew_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROWS   = 8
);
  logic                           start_i;
  logic [NUM_ROWS-1:0]            fifo_empty_i;
  logic [NUM_ROWS*DATA_WIDTH-1:0] fifo_rdata_i;
  logic [NUM_ROWS-1:0]            fifo_rden_o;
  logic [NUM_ROWS*DATA_WIDTH-1:0] pe_data_o;
  logic [NUM_ROWS-1:0]            pe_valid_o;
  logic                           busy_o;
  logic                           stall_o;
  logic                           done_o;

  // Controller / FIFO side: drives start and FIFO status, observes the feeder
  modport master (
    output start_i, fifo_empty_i, fifo_rdata_i,
    input  fifo_rden_o, pe_data_o, pe_valid_o, busy_o, stall_o, done_o
  );

  // Feeder side
  modport slave (
    input  start_i, fifo_empty_i, fifo_rdata_i,
    output fifo_rden_o, pe_data_o, pe_valid_o, busy_o, stall_o, done_o
  );
endinterface

// File: rtl/mmu_skew_feeder.sv
// Skewed read sequencer: drains VEC_LEN words from each of NUM_ROWS show-ahead
// FIFOs, row r delayed by r cycles, whole wavefront stalling on any empty
// active row. PE-side outputs are registered.
module mmu_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROWS   = 8,
  parameter int VEC_LEN    = 70
) (
  input  logic              clk,
  input  logic              rst,
  mmu_skew_feeder_if.slave  bus
);

  localparam int          CNT_RAW = $clog2(VEC_LEN + NUM_ROWS - 1);
  localparam int          CNT_W   = (CNT_RAW == 0) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN + NUM_ROWS - 2);
  localparam int unsigned VL      = VEC_LEN;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CNT_W-1:0]               r_cnt;
  logic [CNT_W-1:0]               w_cnt_nxt;
  logic [NUM_ROWS-1:0]            w_active;
  logic [NUM_ROWS-1:0]            w_rden;
  logic                           w_run;
  logic                           w_stall;
  logic                           w_last;
  logic [NUM_ROWS-1:0]            r_pe_valid;
  logic [NUM_ROWS*DATA_WIDTH-1:0] r_pe_data;
  logic                           r_done;

  // Diagonal window: row r reads while r <= cnt <= r+VEC_LEN-1
  always_comb begin
    w_active = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      w_active[r] = (32'(r_cnt) >= r) && (32'(r_cnt) <= r + VL - 1);
    end
  end

  // State and wavefront counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: advance only on unstalled RUN cycles, leave RUN after LAST
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (!w_stall) begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Combinational outputs: one empty active row freezes every row
  always_comb begin
    w_run   = (r_state == RUN);
    w_last  = (r_cnt == LAST);
    w_stall = w_run && |(w_active & bus.fifo_empty_i);
    w_rden  = (w_run && !w_stall) ? w_active : '0;
  end

  // PE-side output register: capture the FIFO head of every row read this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pe_valid <= '0;
      r_pe_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_pe_valid <= w_rden;
      r_done     <= w_run && !w_stall && w_last;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        r_pe_data[r*DATA_WIDTH +: DATA_WIDTH] <=
          w_rden[r] ? bus.fifo_rdata_i[r*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
  end

  assign bus.fifo_rden_o = w_rden;
  assign bus.stall_o     = w_stall;
  assign bus.busy_o      = w_run;
  assign bus.pe_valid_o  = r_pe_valid;
  assign bus.pe_data_o   = r_pe_data;
  assign bus.done_o      = r_done;

endmodule

// File: tb/tb_mmu_skew_feeder.sv
// Directed bench for mmu_skew_feeder: a 4-row/3-word instance for the main
// sequences and a 2-row/1-word instance for the minimal case.
module tb_mmu_skew_feeder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mmu_skew_feeder_if #(.DATA_WIDTH(32), .NUM_ROWS(4)) bus_a ();
  mmu_skew_feeder_if #(.DATA_WIDTH(32), .NUM_ROWS(2)) bus_b ();

  mmu_skew_feeder #(.DATA_WIDTH(32), .NUM_ROWS(4), .VEC_LEN(3)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mmu_skew_feeder #(.DATA_WIDTH(32), .NUM_ROWS(2), .VEC_LEN(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: row r head word is r*16 + read pointer; emptiness is forced
  int unsigned ptr_a [4];
  int unsigned ptr_b [2];
  logic        clr_a;
  logic        clr_b;
  logic [3:0]  frc_a;

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (clr_a)                       ptr_a[r] <= 0;
      else if (bus_a.fifo_rden_o[r])   ptr_a[r] <= ptr_a[r] + 1;
    end
    for (int r = 0; r < 2; r++) begin
      if (clr_b)                       ptr_b[r] <= 0;
      else if (bus_b.fifo_rden_o[r])   ptr_b[r] <= ptr_b[r] + 1;
    end
  end

  always_comb begin
    bus_a.fifo_empty_i = frc_a;
    bus_a.fifo_rdata_i = '0;
    for (int r = 0; r < 4; r++)
      bus_a.fifo_rdata_i[r*32 +: 32] = 32'(r * 16) + 32'(ptr_a[r]);
  end

  always_comb begin
    bus_b.fifo_empty_i = '0;
    bus_b.fifo_rdata_i = '0;
    for (int r = 0; r < 2; r++)
      bus_b.fifo_rdata_i[r*32 +: 32] = 32'(r * 16) + 32'(ptr_b[r]);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One tile (or more) on instance A. Per-cycle tables, cycle c at bit/nibble c-1:
  // erd = expected rden nibbles, frc = forced-empty nibbles, sp = start_i level,
  // estall/ebusy/edone = expected flag bits. Expected valid is rden one cycle late;
  // expected data follows each row's own word sequence r*16+0,1,2,...
  task automatic run_a(input string name, input int ncyc, input logic [63:0] erd,
                       input logic [63:0] frc, input logic [31:0] sp,
                       input logic [31:0] estall, input logic [31:0] ebusy,
                       input logic [31:0] edone);
    int         seen [4];
    int         nbusy;
    logic [3:0] exp_v;
    logic [31:0] exp_d;
    for (int r = 0; r < 4; r++) seen[r] = 0;
    nbusy = 0;
    @(posedge clk); #1;
    clr_a = 1'b1; bus_a.start_i = 1'b1; frc_a = '0;
    @(posedge clk); #1;
    clr_a = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      bus_a.start_i = sp[c-1];
      frc_a         = frc[4*(c-1) +: 4];
      @(negedge clk);
      check($sformatf("%s c%0d rden", name, c), 64'(bus_a.fifo_rden_o), 64'(erd[4*(c-1) +: 4]));
      check($sformatf("%s c%0d stall", name, c), 64'(bus_a.stall_o), 64'(estall[c-1]));
      check($sformatf("%s c%0d busy", name, c), 64'(bus_a.busy_o), 64'(ebusy[c-1]));
      check($sformatf("%s c%0d done", name, c), 64'(bus_a.done_o), 64'(edone[c-1]));
      exp_v = (c == 1) ? 4'h0 : erd[4*(c-2) +: 4];
      check($sformatf("%s c%0d valid", name, c), 64'(bus_a.pe_valid_o), 64'(exp_v));
      for (int r = 0; r < 4; r++) begin
        if (exp_v[r]) begin
          exp_d = 32'(r * 16 + seen[r]);
          seen[r]++;
        end else begin
          exp_d = '0;
        end
        check($sformatf("%s c%0d data%0d", name, c, r), 64'(bus_a.pe_data_o[r*32 +: 32]), 64'(exp_d));
      end
      if (bus_a.busy_o) nbusy++;
      @(posedge clk); #1;
    end
    bus_a.start_i = 1'b0;
    frc_a         = '0;
    check($sformatf("%s busy_cycles", name), 64'(nbusy), 64'($countones(ebusy)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clr_a = 1'b1; clr_b = 1'b1; frc_a = '0;
    bus_a.start_i = 1'b0;
    bus_b.start_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rden_a",  64'(bus_a.fifo_rden_o), 64'h0);
    check("reset valid_a", 64'(bus_a.pe_valid_o),  64'h0);
    check("reset data_a",  64'(bus_a.pe_data_o),   64'h0);
    check("reset busy_a",  64'(bus_a.busy_o),      64'h0);
    check("reset done_a",  64'(bus_a.done_o),      64'h0);
    check("reset busy_b",  64'(bus_b.busy_o),      64'h0);
    @(posedge clk); #1;
    rst = 1'b0; clr_a = 1'b0; clr_b = 1'b0;

    // Clean tile: rden 1,3,7,E,C,8 then done
    run_a("basic", 7, 64'h08CE731, 64'h0, 32'h0, 32'h0, 32'h3F, 32'h40);

    // Row 1 empty for two cycles at cnt=2
    run_a("stall", 9, 64'h08CE70031, 64'h2200, 32'h0, 32'hC, 32'hFF, 32'h100);

    // All FIFOs empty at start, row 0 filled first, then the rest
    run_a("empty", 10, 64'h08CE731000, 64'hEFFF, 32'h0, 32'h7, 32'h1FF, 32'h200);

    // Reset in the cnt=3 cycle
    @(posedge clk); #1;
    clr_a = 1'b1; bus_a.start_i = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0; bus_a.start_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rstmid pre rden", 64'(bus_a.fifo_rden_o), 64'hE);
    rst = 1'b1;
    #1;
    check("rstmid rden",  64'(bus_a.fifo_rden_o), 64'h0);
    check("rstmid valid", 64'(bus_a.pe_valid_o),  64'h0);
    check("rstmid data",  64'(bus_a.pe_data_o),   64'h0);
    check("rstmid busy",  64'(bus_a.busy_o),      64'h0);
    check("rstmid stall", 64'(bus_a.stall_o),     64'h0);
    check("rstmid done",  64'(bus_a.done_o),      64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid idle busy", 64'(bus_a.busy_o),      64'h0);
    check("rstmid idle rden", 64'(bus_a.fifo_rden_o), 64'h0);
    run_a("replay", 7, 64'h08CE731, 64'h0, 32'h0, 32'h0, 32'h3F, 32'h40);

    // start_i held through the first tile and its done cycle
    run_a("hold", 14, 64'h08CE73108CE731, 64'h0, 32'h7F, 32'h0, 32'h1FBF, 32'h2040);

    // Two rows, one word each
    @(posedge clk); #1;
    clr_b = 1'b1; bus_b.start_i = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0; bus_b.start_i = 1'b0;
    @(negedge clk);
    check("min c1 rden",  64'(bus_b.fifo_rden_o), 64'h1);
    check("min c1 valid", 64'(bus_b.pe_valid_o),  64'h0);
    check("min c1 busy",  64'(bus_b.busy_o),      64'h1);
    @(negedge clk);
    check("min c2 rden",  64'(bus_b.fifo_rden_o), 64'h2);
    check("min c2 valid", 64'(bus_b.pe_valid_o),  64'h1);
    check("min c2 data",  64'(bus_b.pe_data_o),   64'h0);
    check("min c2 done",  64'(bus_b.done_o),      64'h0);
    @(negedge clk);
    check("min c3 rden",  64'(bus_b.fifo_rden_o), 64'h0);
    check("min c3 valid", 64'(bus_b.pe_valid_o),  64'h2);
    check("min c3 data",  64'(bus_b.pe_data_o),   64'h10_0000_0000);
    check("min c3 done",  64'(bus_b.done_o),      64'h1);
    check("min c3 busy",  64'(bus_b.busy_o),      64'h0);
    @(negedge clk);
    check("min c4 done",  64'(bus_b.done_o),      64'h0);
    check("min c4 valid", 64'(bus_b.pe_valid_o),  64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
